// File: rtl/nn_seq_pkg.sv
// Shared types and helpers for the matrix-vector pass sequencer.
package nn_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    // Weight memory read latency; the MAC control pipeline is one stage deep.
    localparam int unsigned MEM_RD_LAT = 1;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvm_index_counter.sv
// Row/column index counter with synchronous clear and a last-value flag.
module mvm_index_counter #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned MAX   = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clear,
    output logic [WIDTH-1:0] index,
    output logic             last_c
);

    assign last_c = (index == WIDTH'(MAX));

    // Clear has priority; wrap at MAX is a safety net, the FSM never steps past it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            index <= '0;
        end else if (clear) begin
            index <= '0;
        end else if (en) begin
            index <= last_c ? '0 : index + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mvm_sequencer.sv
// Sequences one matrix-vector pass: row/column walk, MAC control and result writes.
// Optional build macro MVM_SEQ_STALL_EN lets 'stall' hold the column walk in RUN.
module mvm_sequencer
    import nn_seq_pkg::*;
#(
    parameter  int unsigned NUM_ROWS = 4,
    parameter  int unsigned NUM_COLS = 3,
    localparam int unsigned ROW_W    = idx_width(NUM_ROWS),
    localparam int unsigned COL_W    = idx_width(NUM_COLS)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             clear,
    input  logic             stall,
    output logic [ROW_W-1:0] row_index,
    output logic [COL_W-1:0] col_index,
    output logic             mem_rd_en,
    output logic             mac_en,
    output logic             acc_clear,
    output logic             out_we,
    output logic [ROW_W-1:0] out_addr,
    output logic             busy,
    output logic             done
);

    seq_state_e state_q;
    seq_state_e state_d;

    logic             stall_eff;
    logic             rd_q;
    logic             rd_d;
    logic             mac_d;
    logic             acc_d;
    logic             we_d;
    logic [ROW_W-1:0] addr_d;
    logic             busy_d;
    logic             done_d;
    logic             col_en;
    logic             col_clr;
    logic             row_en;
    logic             row_clr;
    logic             col_last_c;
    logic             row_last_c;

`ifdef MVM_SEQ_STALL_EN
    assign stall_eff = stall;
    // Stall gates the read in the same cycle; the registered read enable holds.
    assign mem_rd_en = rd_q & ~stall;
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign stall_eff    = 1'b0;
    assign mem_rd_en    = rd_q;
`endif

    mvm_index_counter #(
        .WIDTH (COL_W),
        .MAX   (NUM_COLS - 1)
    ) u_col_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (col_en),
        .clear   (col_clr),
        .index   (col_index),
        .last_c  (col_last_c)
    );

    mvm_index_counter #(
        .WIDTH (ROW_W),
        .MAX   (NUM_ROWS - 1)
    ) u_row_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (row_en),
        .clear   (row_clr),
        .index   (row_index),
        .last_c  (row_last_c)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides every transition, including start in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (col_last_c && !stall_eff) state_d = DRAIN;
            DRAIN:   state_d = WRITE;
            WRITE:   state_d = row_last_c ? DONE : RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
        end
    end

    // Output and counter-control logic; output values are for the next cycle.
    always_comb begin
        rd_d    = 1'b0;
        mac_d   = 1'b0;
        acc_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        col_en  = 1'b0;
        col_clr = clear;
        row_en  = 1'b0;
        row_clr = clear;
        if (!clear) begin
            rd_d    = (state_d == RUN);
            we_d    = (state_d == WRITE);
            busy_d  = (state_d != IDLE);
            done_d  = (state_d == DONE);
            addr_d  = (state_d == WRITE) ? row_index : '0;
            mac_d   = mem_rd_en;
            acc_d   = mem_rd_en && (col_index == '0);
            col_en  = (state_q == RUN) && !stall_eff && !col_last_c;
            col_clr = (state_q == WRITE);
            row_en  = (state_q == WRITE) && !row_last_c;
            row_clr = (state_q == DONE);
        end
    end

    // Output registers; mac_en/acc_clear trail the read by the memory latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_q      <= 1'b0;
            mac_en    <= 1'b0;
            acc_clear <= 1'b0;
            out_we    <= 1'b0;
            out_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_q      <= rd_d;
            mac_en    <= mac_d;
            acc_clear <= acc_d;
            out_we    <= we_d;
            out_addr  <= addr_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule
